// File: rtl/conv_output_mixer.sv
// conv_output_mixer: rescale, wet/dry mix and saturate convolution results.
// Optional clip counter enabled by defining CONV_MIX_CLIP_COUNT_EN.
module conv_output_mixer (
  input  logic        audio_clk,
  input  logic        rst_in,
  input  logic        audio_trigger,
  input  logic [15:0] audio_in,
  input  logic [47:0] convolution_result,
  input  logic        produced_convolutional_result,
  input  logic [5:0]  shift_amount,
  input  logic [15:0] wet_gain,
  input  logic [15:0] dry_gain,
  output logic [15:0] audio_out,
  output logic        audio_out_valid,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] clip_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    MIX,
    SUM
  } state_t;

  state_t             state_q;
  logic               prev_ready_q;
  logic signed [15:0] dry_pending_q;
  logic signed [47:0] res_q;
  logic signed [15:0] dry_q;
  logic signed [15:0] wg_q;
  logic signed [15:0] dg_q;
  logic        [5:0]  shift_q;
  logic signed [15:0] wet16_q;
  logic signed [31:0] pw_q;
  logic signed [31:0] pd_q;
  logic signed [15:0] out_q;
  logic               valid_q;
  logic               busy_q;
  logic               ovr_q;

  logic               accept;
  logic        [5:0]  shift_d;
  logic signed [47:0] shifted;
  logic signed [32:0] sum33;
  logic signed [32:0] s;
  logic signed [15:0] wet_sat;
  logic signed [15:0] sum_sat;
  logic               wet_clip;
  logic               sum_clip;

  assign accept  = produced_convolutional_result & ~prev_ready_q;
  assign shift_d = (shift_amount > 6'd47) ? 6'd47 : shift_amount;
  assign shifted = res_q >>> shift_q;
  assign sum33   = $signed({pw_q[31], pw_q}) + $signed({pd_q[31], pd_q});
  assign s       = sum33 >>> 15;

  // Saturate the rescaled wet value and the final mix to 16 bits.
  always_comb begin
    wet_sat  = shifted[15:0];
    wet_clip = 1'b0;
    sum_sat  = s[15:0];
    sum_clip = 1'b0;
    if (shifted > 48'sd32767) begin
      wet_sat  = 16'sh7FFF;
      wet_clip = 1'b1;
    end else if (shifted < -48'sd32768) begin
      wet_sat  = 16'sh8000;
      wet_clip = 1'b1;
    end
    if (s > 33'sd32767) begin
      sum_sat  = 16'sh7FFF;
      sum_clip = 1'b1;
    end else if (s < -33'sd32768) begin
      sum_sat  = 16'sh8000;
      sum_clip = 1'b1;
    end
  end

  // Pipeline FSM: capture, scale, multiply, sum; plus dry latch and overrun.
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q       <= IDLE;
      prev_ready_q  <= 1'b0;
      dry_pending_q <= '0;
      res_q         <= '0;
      dry_q         <= '0;
      wg_q          <= '0;
      dg_q          <= '0;
      shift_q       <= '0;
      wet16_q       <= '0;
      pw_q          <= '0;
      pd_q          <= '0;
      out_q         <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      prev_ready_q <= produced_convolutional_result;
      if (audio_trigger) dry_pending_q <= audio_in;
      if (accept && state_q != IDLE) ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            res_q   <= convolution_result;
            dry_q   <= dry_pending_q;
            wg_q    <= wet_gain;
            dg_q    <= dry_gain;
            shift_q <= shift_d;
            busy_q  <= 1'b1;
            state_q <= SCALE;
          end
        end
        SCALE: begin
          wet16_q <= wet_sat;
          state_q <= MIX;
        end
        MIX: begin
          pw_q    <= wet16_q * wg_q;
          pd_q    <= dry_q * dg_q;
          state_q <= SUM;
        end
        SUM: begin
          out_q   <= sum_sat;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CONV_MIX_CLIP_COUNT_EN
  logic        clip_a_q;
  logic [15:0] clip_cnt_q;

  // Remember a scale-stage clip and count clipped samples, saturating.
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      clip_a_q   <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      if (state_q == SCALE) clip_a_q <= wet_clip;
      if (state_q == SUM && (clip_a_q | sum_clip)
          && clip_cnt_q != 16'hFFFF)
        clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign clip_count = clip_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = wet_clip | sum_clip;
  assign clip_count  = '0;
`endif

  assign audio_out       = out_q;
  assign audio_out_valid = valid_q;
  assign busy            = busy_q;
  assign overrun         = ovr_q;

endmodule
